// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sched_pkg
// Purpose  : Shared constants for the neuron update scheduler: potential word
//            width and the FSM state encodings.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package sched_pkg;

  localparam int POT_W = 32;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] WB      = 3'd4;
  localparam logic [2:0] EMIT    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

endpackage : sched_pkg
`default_nettype wire

// File: rtl/spike_event_port.sv
`default_nettype none
// ============================================================================
// Module   : spike_event_port
// Purpose  : Valid/ready output register for spike events. An event is loaded
//            with its neuron index and held stable until the downstream side
//            accepts it (valid && ready).
// Ports    : CLK, RESET       clock / synchronous active-high reset
//            load, load_idx   capture a new event and its neuron index
//            spike_ready      downstream accepts the event
//            spike_valid      event pending
//            spike_idx        index of the pending event
//            fire             acceptance strobe (valid && ready)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module spike_event_port #(
  parameter int IDX_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             spike_ready,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  output logic             fire
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign fire        = valid_q & spike_ready;
  assign spike_valid = valid_q;
  assign spike_idx   = idx_q;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    if (fire) begin
      valid_d = 1'b0;
    end
    // The scheduler never loads while an event is pending, so load simply
    // overrides the acceptance clear.
    if (load) begin
      valid_d = 1'b1;
      idx_d   = load_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule : spike_event_port
`default_nettype wire

// File: rtl/neuron_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : neuron_update_scheduler
// Purpose  : Time-multiplexes one accelerator across NUM_NEURONS neurons per
//            SNN timestep: fetch potential, present it to the accelerator,
//            wait ACC_LAT cycles, write back, and emit a spike event when the
//            neuron fired.
// Ports    : CLK, RESET                 clock / sync active-high reset
//            timestep_start             start a sweep (pulse)
//            busy, done, overrun        status (done is a pulse, overrun sticky)
//            nidx                       current neuron index
//            pot_rd_en, pot_addr        potential memory read / shared address
//            pot_rd_data                read data, one cycle after pot_rd_en
//            pot_wr_en, pot_wr_data     potential memory write-back
//            acc_potential              potential presented to the accelerator
//            acc_pot_out, acc_spiked    accelerator results
//            spike_valid/idx/ready      spike event handshake
//            spike_count                (SCHED_SPIKE_COUNT_EN only) spikes
//                                       accepted in the current/last sweep
// Config   : SCHED_SPIKE_COUNT_EN - adds the spike_count output and counter.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_update_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4,
  parameter int ACC_LAT     = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             timestep_start,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [IDX_W-1:0] nidx,
  output logic             pot_rd_en,
  output logic [IDX_W-1:0] pot_addr,
  input  logic [POT_W-1:0] pot_rd_data,
  output logic             pot_wr_en,
  output logic [POT_W-1:0] pot_wr_data,
  output logic [POT_W-1:0] acc_potential,
  input  logic [POT_W-1:0] acc_pot_out,
  input  logic             acc_spiked,
`ifdef SCHED_SPIKE_COUNT_EN
  output logic [IDX_W:0]   spike_count,
`endif
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic             spike_ready
);

  localparam int               CNT_W    = (ACC_LAT < 2) ? 1 : $clog2(ACC_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ACC_LAT);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] nidx_q, nidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POT_W-1:0] acc_q, acc_d;
  logic             overrun_q, overrun_d;
`ifdef SCHED_SPIKE_COUNT_EN
  logic [IDX_W:0]   count_q, count_d;
`endif

  logic             w_last;
  logic             w_fire;
  logic             w_ev_load;
  logic             w_ev_valid;
  logic [IDX_W-1:0] w_ev_idx;
  logic             w_wr_en;

  assign w_last    = (nidx_q == LAST_IDX);
  assign w_ev_load = (state_q == WB) && acc_spiked;

  spike_event_port #(
    .IDX_W (IDX_W)
  ) u_spike_port (
    .CLK         (CLK),
    .RESET       (RESET),
    .load        (w_ev_load),
    .load_idx    (nidx_q),
    .spike_ready (spike_ready),
    .spike_valid (w_ev_valid),
    .spike_idx   (w_ev_idx),
    .fire        (w_fire)
  );

  always_comb begin
    state_d   = state_q;
    nidx_d    = nidx_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    overrun_d = overrun_q | (timestep_start && (state_q != IDLE));
`ifdef SCHED_SPIKE_COUNT_EN
    count_d   = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (timestep_start) begin
          state_d = FETCH;
          nidx_d  = '0;
`ifdef SCHED_SPIKE_COUNT_EN
          count_d = '0;
`endif
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        acc_d   = pot_rd_data;
        cnt_d   = LAT_LOAD;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        // Counter is loaded with ACC_LAT, so COMPUTE lasts exactly ACC_LAT
        // cycles and acc_pot_out is valid on entry to WB.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = WB;
        end
      end
      WB: begin
        if (acc_spiked) begin
          state_d = EMIT;
        end else if (w_last) begin
          state_d = DONE;
        end else begin
          nidx_d  = nidx_q + 1'b1;
          state_d = FETCH;
        end
      end
      EMIT: begin
        if (w_fire) begin
`ifdef SCHED_SPIKE_COUNT_EN
          count_d = count_q + 1'b1;
`endif
          if (w_last) begin
            state_d = DONE;
          end else begin
            nidx_d  = nidx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      nidx_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      overrun_q <= 1'b0;
`ifdef SCHED_SPIKE_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      nidx_q    <= nidx_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      overrun_q <= overrun_d;
`ifdef SCHED_SPIKE_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  // Strobes are masked by RESET so an abort issues no write, read or spike
  // in the very cycle reset is asserted.
  assign w_wr_en       = (state_q == WB) && !RESET;
  assign pot_wr_en     = w_wr_en;
  assign pot_wr_data   = w_wr_en ? acc_pot_out : '0;
  assign pot_rd_en     = (state_q == FETCH) && !RESET;
  assign pot_addr      = nidx_q;
  assign nidx          = nidx_q;
  assign acc_potential = acc_q;
  assign spike_valid   = w_ev_valid && !RESET;
  assign spike_idx     = w_ev_idx;
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign overrun       = overrun_q;
`ifdef SCHED_SPIKE_COUNT_EN
  assign spike_count   = count_q;
`endif

endmodule : neuron_update_scheduler
`default_nettype wire

// File: tb/tb_neuron_update_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_neuron_update_scheduler
// Purpose  : Directed self-checking bench for neuron_update_scheduler with a
//            behavioural potential memory and a "p+1" accelerator model.
// Config   : SCHED_SPIKE_COUNT_EN - also exercises the spike counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_update_scheduler;

  localparam int N   = 16;
  localparam int IW  = 4;
  localparam int LAT = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          timestep_start = 1'b0;
  logic          spike_ready = 1'b1;
  logic          busy, done, overrun, pot_rd_en, pot_wr_en, spike_valid;
  logic [IW-1:0] nidx, pot_addr, spike_idx;
  logic [31:0]   pot_rd_data, pot_wr_data, acc_potential, acc_pot_out;
  logic          acc_spiked;
`ifdef SCHED_SPIKE_COUNT_EN
  logic [IW:0]   spike_count;
`endif

  logic [31:0]   mem [N];
  logic          preload = 1'b0;
  logic [N-1:0]  spike_mask = '0;
  logic          clr = 1'b0;

  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 CLK = ~CLK;

  neuron_update_scheduler #(
    .NUM_NEURONS (N),
    .IDX_W       (IW),
    .ACC_LAT     (LAT)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .timestep_start (timestep_start),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun),
    .nidx           (nidx),
    .pot_rd_en      (pot_rd_en),
    .pot_addr       (pot_addr),
    .pot_rd_data    (pot_rd_data),
    .pot_wr_en      (pot_wr_en),
    .pot_wr_data    (pot_wr_data),
    .acc_potential  (acc_potential),
    .acc_pot_out    (acc_pot_out),
    .acc_spiked     (acc_spiked),
`ifdef SCHED_SPIKE_COUNT_EN
    .spike_count    (spike_count),
`endif
    .spike_valid    (spike_valid),
    .spike_idx      (spike_idx),
    .spike_ready    (spike_ready)
  );

  // Potential memory: one-cycle read latency, write on the strobe edge.
  always @(posedge CLK) begin
    if (preload) begin
      for (int k = 0; k < N; k++) mem[k] <= 32'(k * 10);
    end else begin
      if (pot_rd_en) pot_rd_data <= mem[pot_addr];
      if (pot_wr_en) mem[pot_addr] <= pot_wr_data;
    end
  end

  assign acc_pot_out = acc_potential + 32'd1;
  assign acc_spiked  = spike_mask[nidx];

  // Transaction monitor, sampled 1 ns before each rising edge.
  int            rd_n, wr_n, sv_cycles, ev_n, hold_bad;
  logic [IW-1:0] rd_log [64];
  logic [IW-1:0] wr_log [64];
  logic [IW-1:0] ev_log [8];
  logic          prev_pend;
  logic [IW-1:0] prev_idx;

  always @(negedge CLK) begin
    #4;
    if (clr) begin
      rd_n = 0; wr_n = 0; sv_cycles = 0; ev_n = 0; hold_bad = 0;
      prev_pend = 1'b0; prev_idx = '0;
    end else begin
      if (pot_rd_en && rd_n < 64) begin rd_log[rd_n] = pot_addr; rd_n++; end
      if (pot_wr_en && wr_n < 64) begin wr_log[wr_n] = pot_addr; wr_n++; end
      if (spike_valid) begin
        sv_cycles++;
        if (prev_pend && spike_idx != prev_idx) hold_bad++;
        if (spike_ready && ev_n < 8) begin ev_log[ev_n] = spike_idx; ev_n++; end
      end
      prev_pend = spike_valid && !spike_ready;
      prev_idx  = spike_idx;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge CLK); clr = 1'b1;
    @(negedge CLK); clr = 1'b0;
  endtask

  // Runs one sweep. Cycle k is the k-th cycle after the start edge. Optional
  // extra start at cycle inj, reset at cycle rst_at, ready low st_from..st_to.
  task automatic run_sweep(input int inj, input int rst_at, input int st_from,
                           input int st_to, output int done_cyc);
    int  k;
    bit  fin;
    k = 0; fin = 0; done_cyc = -1;
    @(negedge CLK); timestep_start = 1'b1;
    while (!fin) begin
      @(negedge CLK);
      k++;
      timestep_start = (k == inj);
      RESET          = (k == rst_at);
      spike_ready    = !(k >= st_from && k <= st_to);
      #4;
      if (k == 1) check("busy_c1", 32'(busy), 32'd1);
      if (rst_at > 0 && k == rst_at + 1) begin
        check("rst_outs", {busy, done, overrun, pot_rd_en, pot_wr_en, spike_valid,
                           nidx, pot_addr, spike_idx}, 32'd0);
        check("rst_wdata", pot_wr_data, 32'd0);
        check("rst_accp", acc_potential, 32'd0);
        fin = 1;
      end else if (done) begin
        check("busy_done", 32'(busy), 32'd0);
        done_cyc = k;
        fin = 1;
      end else if (k > 400) begin
        check("timeout", 32'(k), 32'd0);
        fin = 1;
      end
    end
    @(negedge CLK);
    timestep_start = 1'b0; RESET = 1'b0; spike_ready = 1'b1;
    #4;
    if (rst_at <= 0) check("done_pulse", 32'(done), 32'd0);
  endtask

  int dc;

  initial begin
    clr = 1'b1; preload = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0; preload = 1'b0;
    #4;
    check("reset_outs", {busy, done, overrun, pot_rd_en, pot_wr_en, spike_valid,
                         nidx, pot_addr, spike_idx}, 32'd0);
    check("reset_accp", acc_potential, 32'd0);
    clear_mon();

    // Full sweep, no spikes.
    run_sweep(-1, -1, -1, -1, dc);
    check("t1_done_cyc", 32'(dc), 32'd81);
    check("t1_rd_n", 32'(rd_n), 32'd16);
    check("t1_wr_n", 32'(wr_n), 32'd16);
    for (int i = 0; i < N; i++) begin
      check($sformatf("t1_rd_addr%0d", i), 32'(rd_log[i]), 32'(i));
      check($sformatf("t1_wr_addr%0d", i), 32'(wr_log[i]), 32'(i));
      check($sformatf("t2_mem%0d", i), mem[i], 32'(i * 10 + 1));
    end
    check("t2_no_spike", 32'(sv_cycles), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);

    // Neuron 5 spikes, ready low for its first four EMIT cycles (31..34).
    clear_mon();
    spike_mask = 16'h0020;
    run_sweep(-1, -1, 31, 34, dc);
    check("t3_done_cyc", 32'(dc), 32'd86);
    check("t3_sv_cycles", 32'(sv_cycles), 32'd5);
    check("t3_events", 32'(ev_n), 32'd1);
    check("t3_ev_idx", 32'(ev_log[0]), 32'd5);
    check("t3_hold", 32'(hold_bad), 32'd0);
    check("t3_wr_n", 32'(wr_n), 32'd16);
    check("t3_mem5", mem[5], 32'd52);

    // Second start mid-sweep.
    clear_mon();
    spike_mask = '0;
    run_sweep(20, -1, -1, -1, dc);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_done_cyc", 32'(dc), 32'd81);
    check("t4_wr_n", 32'(wr_n), 32'd16);

    // Reset at cycle 30 (WB of neuron 5): only neurons 0..4 written.
    clear_mon();
    run_sweep(-1, 30, -1, -1, dc);
    repeat (20) @(negedge CLK);
    check("t5_wr_n_abort", 32'(wr_n), 32'd5);
    check("t5_idle_busy", 32'(busy), 32'd0);
    clear_mon();
    run_sweep(-1, -1, -1, -1, dc);
    check("t5_done_cyc", 32'(dc), 32'd81);
    check("t5_wr_n", 32'(wr_n), 32'd16);
    check("t5_wr_last", 32'(wr_log[15]), 32'd15);
    check("t5_overrun", 32'(overrun), 32'd0);

`ifdef SCHED_SPIKE_COUNT_EN
    // Neurons 0, 7 and 15 spike.
    clear_mon();
    spike_mask = 16'h8081;
    run_sweep(-1, -1, -1, -1, dc);
    check("t6_done_cyc", 32'(dc), 32'd84);
    check("t6_count", 32'(spike_count), 32'd3);
    check("t6_events", 32'(ev_n), 32'd3);
    check("t6_ev0", 32'(ev_log[0]), 32'd0);
    check("t6_ev1", 32'(ev_log[1]), 32'd7);
    check("t6_ev2", 32'(ev_log[2]), 32'd15);
    @(negedge CLK); timestep_start = 1'b1;
    @(negedge CLK); timestep_start = 1'b0;
    #4;
    check("t6_count_clr", 32'(spike_count), 32'd0);
    begin
      int w;
      w = 0;
      while (busy && w < 400) begin @(negedge CLK); w++; end
      check("t6_finish", 32'(w < 400), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_neuron_update_scheduler
`default_nettype wire
